// File: rtl/seq_add_pkg.sv
// Shared types and elaboration helpers for the sequential slice adder.
package seq_add_pkg;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  function automatic int unsigned nbeats(input int unsigned width, input int unsigned slice);
    if (slice == 0) return 0;
    return width / slice;
  endfunction

  // Elaboration check: the slice must tile the operand width exactly.
  function automatic bit cfg_ok(input int unsigned width, input int unsigned slice);
    if (slice < 1) return 1'b0;
    return (width % slice) == 0;
  endfunction

endpackage

// File: rtl/add_slice.sv
// Combinational SLICE-bit ripple-carry chain of full-adder cells.
module add_slice #(
  parameter int unsigned SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] sum,
  output logic             cout
);

  logic [SLICE:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < SLICE; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[SLICE];

endmodule

// File: rtl/seq_slice_adder_ctrl.sv
// Multi-cycle adder reusing one SLICE-bit slice per beat, valid/ready on both sides.
// Optional SEQ_ADD_SUBTRACT_EN adds op_sub_i for a-b (stores ~b, forces carry-in to 1).
module seq_slice_adder_ctrl
  import seq_add_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
`ifdef SEQ_ADD_SUBTRACT_EN
  input  logic             op_sub_i,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             busy_o
);

  localparam int unsigned NBEATS = nbeats(WIDTH, SLICE);
  localparam int unsigned BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEATS - 1);

  if (!cfg_ok(WIDTH, SLICE)) begin : g_cfg_err
    $error("seq_slice_adder_ctrl: WIDTH must be a nonzero multiple of SLICE");
  end

  state_e            state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic              carry_q, carry_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic              cout_q, cout_d;

  logic [SLICE-1:0]  slice_a, slice_b, slice_sum;
  logic              slice_cout;

  assign slice_a = a_q[int'(beat_q) * SLICE +: SLICE];
  assign slice_b = b_q[int'(beat_q) * SLICE +: SLICE];

  add_slice #(
    .SLICE(SLICE)
  ) u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = a_i;
          b_d     = b_i;
          carry_d = cin_i;
`ifdef SEQ_ADD_SUBTRACT_EN
          if (op_sub_i) begin
            b_d     = ~b_i;
            carry_d = 1'b1;
          end
`endif
          beat_d  = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        sum_d[int'(beat_q) * SLICE +: SLICE] = slice_sum;
        carry_d = slice_cout;
        if (beat_q == LAST_BEAT) begin
          cout_d  = slice_cout;
          beat_d  = '0;
          state_d = StDone;
        end else begin
          beat_d = beat_q + BEAT_W'(1);
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      beat_q  <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy_o    = (state_q != StIdle);
  assign sum_o     = sum_q;
  assign cout_o    = cout_q;

endmodule

// File: tb/tb_seq_slice_adder_ctrl.sv
// Self-checking bench for seq_slice_adder_ctrl (WIDTH=16, SLICE=4), random + directed.
module tb_seq_slice_adder_ctrl;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned SLICE = 4;
  localparam int LAT = 4;
  localparam int PERIOD = 6;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a_i = '0;
  logic [WIDTH-1:0] b_i = '0;
  logic             cin_i = 1'b0;
`ifdef SEQ_ADD_SUBTRACT_EN
  logic             op_sub = 1'b0;
`endif
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] sum_o;
  logic             cout_o;
  logic             busy_o;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  seq_slice_adder_ctrl #(
    .WIDTH(WIDTH),
    .SLICE(SLICE)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_i       (a_i),
    .b_i       (b_i),
    .cin_i     (cin_i),
`ifdef SEQ_ADD_SUBTRACT_EN
    .op_sub_i  (op_sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum_o     (sum_o),
    .cout_o    (cout_o),
    .busy_o    (busy_o)
  );

  // Reference: plain integer arithmetic, {cout, sum}.
  function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                           input logic cin, input logic sub);
    logic [WIDTH:0] r;
    if (sub) r = {(a >= b) ? 1'b1 : 1'b0, a - b};
    else     r = 17'(a) + 17'(b) + 17'(cin);
    return r;
  endfunction

  // Present operands and wait (bounded) for the accept edge; returns just after it.
  task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin,
                          input logic sub, output bit accepted);
    a_i = a; b_i = b; cin_i = cin;
`ifdef SEQ_ADD_SUBTRACT_EN
    op_sub = sub;
`endif
    in_valid = 1'b1;
    accepted = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (in_ready) begin
        accepted = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat, output bit ok);
    lat = 0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      lat++;
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic finish_op();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    tests++; if (sum_o !== 16'h0) begin fails++; $display("FAIL reset_sum: got %h want 0000", sum_o); end
    tests++; if (cout_o !== 1'b0) begin fails++; $display("FAIL reset_cout: got %b want 0", cout_o); end
    tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [WIDTH-1:0] va [3];
    logic [WIDTH-1:0] vb [3];
    logic             vc [3];
    logic [WIDTH:0]   exp;
    bit acc, ok;
    int lat;
    va[0] = 16'h1234; vb[0] = 16'h4321; vc[0] = 1'b0;
    va[1] = 16'hFFFF; vb[1] = 16'h0001; vc[1] = 1'b0;
    va[2] = 16'h0000; vb[2] = 16'h0000; vc[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp = model(va[i], vb[i], vc[i], 1'b0);
      start_op(va[i], vb[i], vc[i], 1'b0, acc);
      tests++; if (!acc) begin fails++; $display("FAIL dir%0d_accept: not accepted", i); end
      tests++; if (busy_o !== 1'b1) begin fails++; $display("FAIL dir%0d_busy: got %b want 1", i, busy_o); end
      wait_done(lat, ok);
      tests++; if (!ok || lat != LAT) begin
        fails++; $display("FAIL dir%0d_latency: got %0d (valid=%b) want %0d", i, lat, ok, LAT);
      end
      tests++; if ({cout_o, sum_o} !== exp) begin
        fails++; $display("FAIL dir%0d_result: got %b_%h want %b_%h", i, cout_o, sum_o, exp[WIDTH],
                          exp[WIDTH-1:0]);
      end
      finish_op();
      tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        fails++; $display("FAIL dir%0d_release: got valid=%b ready=%b want 0/1", i, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [WIDTH-1:0] a, b;
    logic [WIDTH:0]   exp;
    bit acc, ok;
    int lat;
    a = 16'($urandom); b = 16'($urandom);
    exp = model(a, b, 1'b1, 1'b0);
    start_op(a, b, 1'b1, 1'b0, acc);
    wait_done(lat, ok);
    tests++; if (!ok) begin fails++; $display("FAIL bp_done: out_valid never rose"); end
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      tests++; if ({cout_o, sum_o} !== exp || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        fails++; $display("FAIL bp_hold%0d: got %b_%h ready=%b valid=%b want %b_%h 0 1", i, cout_o,
                          sum_o, in_ready, out_valid, exp[WIDTH], exp[WIDTH-1:0]);
      end
    end
    finish_op();
    tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy_o !== 1'b0) begin
      fails++; $display("FAIL bp_release: got ready=%b valid=%b busy=%b want 1 0 0", in_ready,
                        out_valid, busy_o);
    end
  endtask

  task automatic test_reset_mid_run();
    bit acc, ok;
    int lat;
    start_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, acc);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    tests++; if (out_valid !== 1'b0 || sum_o !== 16'h0 || cout_o !== 1'b0 || in_ready !== 1'b1 ||
                 busy_o !== 1'b0) begin
      fails++; $display("FAIL midrst_outputs: got v=%b s=%h c=%b r=%b b=%b want 0 0000 0 1 0",
                        out_valid, sum_o, cout_o, in_ready, busy_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    start_op(16'h0003, 16'h0004, 1'b0, 1'b0, acc);
    wait_done(lat, ok);
    tests++; if (!ok || sum_o !== 16'h0007 || cout_o !== 1'b0) begin
      fails++; $display("FAIL midrst_after: got %b_%h valid=%b want 0_0007", cout_o, sum_o, ok);
    end
    finish_op();
  endtask

  task automatic test_back_to_back();
    logic [WIDTH:0] q[$];
    logic [WIDTH:0] exp;
    int last_acc = -1;
    int n_acc = 0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 60; cyc++) begin
      a_i = 16'($urandom); b_i = 16'($urandom); cin_i = 1'($urandom);
      if (in_ready) begin
        q.push_back(model(a_i, b_i, cin_i, 1'b0));
        n_acc++;
        if (last_acc >= 0) begin
          tests++; if (cyc - last_acc != PERIOD) begin
            fails++; $display("FAIL b2b_gap: got %0d want %0d", cyc - last_acc, PERIOD);
          end
        end
        last_acc = cyc;
      end
      if (out_valid) begin
        tests++;
        if (q.size() == 0) begin
          fails++; $display("FAIL b2b_extra: got result %h with no accept pending want none", sum_o);
        end else begin
          exp = q.pop_front();
          if ({cout_o, sum_o} !== exp) begin
            fails++; $display("FAIL b2b_result: got %b_%h want %b_%h", cout_o, sum_o, exp[WIDTH],
                              exp[WIDTH-1:0]);
          end
        end
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    tests++; if (n_acc != 10 || q.size() != 0) begin
      fails++; $display("FAIL b2b_count: got %0d accepts %0d pending want 10 0", n_acc, q.size());
    end
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] a, b;
    logic             c;
    logic [WIDTH:0]   exp;
    bit acc, ok;
    int lat;
    for (int i = 0; i < 20; i++) begin
      a = 16'($urandom); b = 16'($urandom); c = 1'($urandom);
      exp = model(a, b, c, 1'b0);
      start_op(a, b, c, 1'b0, acc);
      wait_done(lat, ok);
      repeat ($urandom_range(3)) begin @(posedge clk); #1; end
      tests++; if (!acc || !ok || {cout_o, sum_o} !== exp) begin
        fails++; $display("FAIL rand%0d: got %b_%h (acc=%b valid=%b) for %h+%h+%b want %b_%h", i,
                          cout_o, sum_o, acc, ok, a, b, c, exp[WIDTH], exp[WIDTH-1:0]);
      end
      finish_op();
    end
  endtask

`ifdef SEQ_ADD_SUBTRACT_EN
  task automatic test_subtract();
    logic [WIDTH-1:0] va [2];
    logic [WIDTH-1:0] vb [2];
    logic [WIDTH:0]   exp;
    bit acc, ok;
    int lat;
    va[0] = 16'h0005; vb[0] = 16'h0007;
    va[1] = 16'h0007; vb[1] = 16'h0005;
    for (int i = 0; i < 2; i++) begin
      exp = model(va[i], vb[i], 1'b0, 1'b1);
      start_op(va[i], vb[i], 1'($urandom), 1'b1, acc);
      wait_done(lat, ok);
      tests++; if (!ok || {cout_o, sum_o} !== exp) begin
        fails++; $display("FAIL sub%0d: got %b_%h want %b_%h", i, cout_o, sum_o, exp[WIDTH],
                          exp[WIDTH-1:0]);
      end
      finish_op();
    end
    op_sub = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
`ifdef SEQ_ADD_SUBTRACT_EN
    test_subtract();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
